// File: rtl/cpu_defs.sv
// Shared CPU constants: reset PC, the NOP instruction word and the fetch FSM encoding.
package cpu_defs;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register, fetch FSM, stall hold buffer and IF/ID register.
module if_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        redirect,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_add4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_add4,
  output logic        if_id_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pa4_q, pa4_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_plus4;

  assign pc_plus4      = pc_q + 32'd4;
  assign pc            = pc_q;
  assign pc_add4       = pc_plus4;
  assign imem_addr     = pc_q;
  assign imem_req      = (state_q != S_HOLD);
  assign if_id_instr   = instr_q;
  assign if_id_pc_add4 = pa4_q;
  assign if_id_valid   = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_WORD;
      tgt_q   <= 32'd0;
      instr_q <= NOP_WORD;
      pa4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      pa4_q   <= pa4_d;
      valid_q <= valid_d;
    end
  end

  // Stall outranks redirect everywhere; a stall with no completion leaves IF/ID untouched.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    pa4_d   = pa4_q;
    valid_d = valid_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          if (stall) begin
            buf_d   = imem_rdata;
            state_d = S_HOLD;
          end else if (redirect) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            pc_d    = npc;
          end else begin
            instr_d = imem_rdata;
            pa4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = npc;
          end
        end else if (!stall && redirect) begin
          valid_d = 1'b0;
          tgt_d   = npc;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Request stays on the old pc until memory answers; that answer is thrown away.
        if (imem_ack) begin
          pc_d    = tgt_q;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          if (redirect) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end else begin
            instr_d = buf_q;
            pa4_d   = pc_plus4;
            valid_d = 1'b1;
          end
          pc_d    = npc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios then random traffic against a behavioural model.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic        redirect, stall;
  logic [31:0] pc, pc_add4, imem_addr;
  logic        imem_req, imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr, if_id_pc_add4;
  logic        if_id_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what the fetch stage should look like from outside.
  logic [31:0] m_pc, m_buf, m_tgt, m_instr, m_pa4;
  logic        m_valid, m_holding, m_draining;

  if_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .npc(npc), .redirect(redirect), .stall(stall),
    .pc(pc), .pc_add4(pc_add4), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc_add4(if_id_pc_add4), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_front(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".addr"}, imem_addr, m_pc);
    chk({tag, ".pc_add4"}, pc_add4, m_pc + 32'd4);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, !m_holding});
  endtask

  task automatic chk_ifid(input string tag);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".pa4"}, if_id_pc_add4, m_pa4);
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_buf = 0; m_tgt = 0;
    m_instr = 0; m_pa4 = 0; m_valid = 0;
    m_holding = 0; m_draining = 0;
  endtask

  task automatic model_step(input logic a, s, r, input logic [31:0] n, d);
    if (m_holding) begin
      if (!s) begin
        if (r) begin m_valid = 0; m_instr = 0; end
        else begin m_instr = m_buf; m_pa4 = m_pc + 4; m_valid = 1; end
        m_pc = n; m_holding = 0;
      end
    end else if (m_draining) begin
      if (a) begin m_pc = m_tgt; m_draining = 0; end
    end else if (a) begin
      if (s) begin m_buf = d; m_holding = 1; end
      else if (r) begin m_valid = 0; m_instr = 0; m_pc = n; end
      else begin m_instr = d; m_pa4 = m_pc + 4; m_valid = 1; m_pc = n; end
    end else if (!s && r) begin
      m_valid = 0; m_tgt = n; m_draining = 1;
    end
  endtask

  // One clock: drive at the negedge, check combinational outputs, advance model, check IF/ID.
  task automatic cyc(input string tag, input logic a, s, r, input logic [31:0] n, d);
    imem_ack = a; stall = s; redirect = r; npc = n; imem_rdata = d;
    #1 chk_front(tag);
    model_step(a, s, r, n, d);
    @(negedge clk);
    chk_ifid(tag);
  endtask

  task automatic do_reset(input string tag, input logic a);
    rst = 1; imem_ack = a; imem_rdata = 32'hDEAD_BEEF; stall = 0; redirect = 0; npc = 32'h0000_5000;
    model_reset();
    @(negedge clk);
    rst = 0;
    #1 chk_front(tag);
    chk_ifid(tag);
  endtask

  initial begin
    rst = 1; npc = 0; redirect = 0; stall = 0; imem_ack = 0; imem_rdata = 0;
    model_reset();
    @(negedge clk);
    do_reset("reset", 1'b0);

    // Zero-wait sequential fetch.
    for (int i = 0; i < 3; i++) cyc("seq", 1, 0, 0, m_pc + 4, 32'h1000_0000 + i);
    chk("seq.pc_end", pc, 32'h0000_300C);
    chk("seq.pa4_end", if_id_pc_add4, 32'h0000_300C);

    // Ack under stall, held three cycles, then released.
    cyc("hold0", 1, 1, 0, 32'h0000_7000, 32'hCAFE_0001);
    cyc("hold1", 0, 1, 1, 32'h0000_7000, 32'h0BAD_0BAD);
    cyc("hold2", 1, 1, 0, 32'h0000_7000, 32'h0BAD_0BAD);
    cyc("hold_rel", 0, 0, 0, m_pc + 4, 32'h0BAD_0BAD);
    chk("hold.word", if_id_instr, 32'hCAFE_0001);
    cyc("after_hold", 1, 0, 0, m_pc + 4, 32'h2000_0000);

    // Redirect in an ack cycle.
    cyc("redir_ack", 1, 0, 1, 32'h0000_3040, 32'h3333_3333);
    chk("redir.pc", pc, 32'h0000_3040);

    // Slow memory, redirect in the first wait cycle.
    cyc("drain0", 0, 0, 1, 32'h0000_3100, 0);
    cyc("drain1", 0, 0, 0, 32'h0000_9999, 0);
    cyc("drain_ack", 1, 0, 0, 32'h0000_9999, 32'h4444_4444);
    chk("drain.pc", pc, 32'h0000_3100);
    cyc("drain_next", 1, 0, 0, m_pc + 4, 32'h5555_5555);

    // Stall and redirect together.
    cyc("stall_redir", 0, 1, 1, 32'h0000_8888, 0);

    // Wrap of pc+4.
    cyc("wrap_set", 1, 0, 0, 32'hFFFF_FFFC, 32'h6666_6666);
    chk("wrap.pa4", pc_add4, 32'h0000_0000);
    cyc("wrap_ack", 1, 0, 0, 32'h0000_3000, 32'h7777_7777);

    // Reset from HOLD and from DRAIN, with an ack present in the reset cycle.
    cyc("pre_hold", 1, 1, 0, 0, 32'hAAAA_AAAA);
    do_reset("rst_hold", 1'b1);
    cyc("pre_drain", 0, 0, 1, 32'h0000_4400, 0);
    do_reset("rst_drain", 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] n;
      int sel;
      sel = $urandom_range(0, 9);
      n = (sel < 6) ? m_pc + 4 : (sel < 9) ? ($urandom & 32'hFFFF_FFFC) : 32'hFFFF_FFFC;
      cyc("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0, n, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
